// File: rtl/uart_rx_wb.sv
// 8N1 UART receiver feeding a small RX FIFO, drained through a 2-bit-address register bus.
// wb_int_o flags waiting data or error conditions when enabled.
module uart_rx_wb #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       wb_clk_i,
    input  logic       rst_i,
    input  logic       wb_cyc_i,
    input  logic       wb_we_i,
    input  logic [1:0] wb_addr_i,
    input  logic [7:0] wb_datw_i,
    output logic [7:0] wb_datr_o,
    output logic       wb_int_o,
    input  logic       uart_rx
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_FULL = 16'(CLK_DIV);
    localparam logic [15:0] DIV_HALF = 16'(CLK_DIV / 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Synchroniser and edge history reset low, so a line stuck low after reset
    // cannot start a frame until it has first been seen high.
    logic rx_meta_reg, rx_s_reg, rx_prev_reg;

    always_ff @(posedge wb_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_meta_reg <= 1'b0;
            rx_s_reg    <= 1'b0;
            rx_prev_reg <= 1'b0;
        end else begin
            rx_meta_reg <= uart_rx;
            rx_s_reg    <= rx_meta_reg;
            rx_prev_reg <= rx_s_reg;
        end
    end

    logic rx_fall;
    assign rx_fall = rx_prev_reg & ~rx_s_reg;

    rx_state_t   state_reg;
    logic [15:0] baud_cnt_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic        cnt_expired;

    assign cnt_expired = (baud_cnt_reg == 16'd1);

    always_ff @(posedge wb_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= 16'd0;
            bit_idx_reg  <= 3'd0;
            shift_reg    <= 8'h00;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (rx_fall) begin
                        state_reg    <= ST_START;
                        baud_cnt_reg <= DIV_HALF;
                    end
                end
                ST_START: begin
                    if (cnt_expired) begin
                        if (!rx_s_reg) begin
                            state_reg    <= ST_DATA;
                            baud_cnt_reg <= DIV_FULL;
                            bit_idx_reg  <= 3'd0;
                        end else begin
                            state_reg    <= ST_IDLE;
                            baud_cnt_reg <= DIV_HALF;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_expired) begin
                        shift_reg    <= {rx_s_reg, shift_reg[7:1]};
                        baud_cnt_reg <= DIV_FULL;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= ST_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt_expired) begin
                        state_reg    <= rx_s_reg ? ST_IDLE : ST_BREAK;
                        baud_cnt_reg <= DIV_FULL;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 16'd1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s_reg) begin
                        state_reg    <= ST_IDLE;
                        baud_cnt_reg <= DIV_HALF;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    baud_cnt_reg <= 16'd0;
                end
            endcase
        end
    end

    logic stop_sample, rx_push, ferr_set;
    assign stop_sample = (state_reg == ST_STOP) && cnt_expired;
    assign rx_push     = stop_sample & rx_s_reg;
    assign ferr_set    = stop_sample & ~rx_s_reg;

    // FIFO with one extra pointer bit to tell full from empty.
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0] fifo_count;
    logic        fifo_empty, fifo_full;

    assign fifo_count = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    logic rd_access, wr_access, pop, push_ok, ovr_set;
    assign rd_access = wb_cyc_i & ~wb_we_i;
    assign wr_access = wb_cyc_i & wb_we_i;
    assign pop       = rd_access && (wb_addr_i == 2'd0) && !fifo_empty;
    // A coincident pop frees the slot first, so a full FIFO still accepts the push.
    assign push_ok   = rx_push & (~fifo_full | pop);
    assign ovr_set   = rx_push & fifo_full & ~pop;

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    logic ovr_reg, ferr_reg, ie_reg;
    logic clr_ovr, clr_ferr;
    assign clr_ovr  = wr_access && (wb_addr_i == 2'd1) && wb_datw_i[2];
    assign clr_ferr = wr_access && (wb_addr_i == 2'd1) && wb_datw_i[3];

    always_ff @(posedge wb_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovr_reg  <= 1'b0;
            ferr_reg <= 1'b0;
            ie_reg   <= 1'b0;
        end else begin
            // Set terms are ORed last so a same-cycle set beats a W1C clear.
            ovr_reg  <= ovr_set  | (ovr_reg  & ~clr_ovr);
            ferr_reg <= ferr_set | (ferr_reg & ~clr_ferr);
            if (wr_access && (wb_addr_i == 2'd2)) begin
                ie_reg <= wb_datw_i[0];
            end
        end
    end

    logic unused_datw;
    assign unused_datw = ^{wb_datw_i[7:4], wb_datw_i[1]};

    logic [7:0] rd_mux;
    always_comb begin
        rd_mux = 8'h00;
        case (wb_addr_i)
            2'd0: rd_mux = fifo_empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];
            2'd1: rd_mux = {4'b0000, ferr_reg, ovr_reg, fifo_full, ~fifo_empty};
            2'd2: rd_mux = {7'b0000000, ie_reg};
            2'd3: rd_mux = 8'(fifo_count);
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_datr_o <= 8'h00;
            wb_int_o  <= 1'b0;
        end else begin
            if (rd_access) begin
                wb_datr_o <= rd_mux;
            end
            wb_int_o <= ie_reg & (~fifo_empty | ovr_reg | ferr_reg);
        end
    end

endmodule

// File: tb/tb_uart_rx_wb.sv
// Directed bench for uart_rx_wb at CLK_DIV=8, FIFO_DEPTH=8: table of single frames,
// then glitch, overrun, push/pop collision, interrupt and mid-frame reset sequences.
module tb_uart_rx_wb;

    localparam int CLK_DIV    = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int FRAME_LEN  = 10 * CLK_DIV;

    logic       wb_clk_i  = 1'b0;
    logic       rst_i     = 1'b0;
    logic       wb_cyc_i  = 1'b0;
    logic       wb_we_i   = 1'b0;
    logic [1:0] wb_addr_i = 2'd0;
    logic [7:0] wb_datw_i = 8'h00;
    logic [7:0] wb_datr_o;
    logic       wb_int_o;
    logic       uart_rx   = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_wb #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .rst_i     (rst_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_we_i   (wb_we_i),
        .wb_addr_i (wb_addr_i),
        .wb_datw_i (wb_datw_i),
        .wb_datr_o (wb_datr_o),
        .wb_int_o  (wb_int_o),
        .uart_rx   (uart_rx)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%02h", name, act);
        end
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        wb_cyc_i  = 1'b1;
        wb_we_i   = 1'b0;
        wb_addr_i = a;
        tick();
        wb_cyc_i  = 1'b0;
        d         = wb_datr_o;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        wb_cyc_i  = 1'b1;
        wb_we_i   = 1'b1;
        wb_addr_i = a;
        wb_datw_i = d;
        tick();
        wb_cyc_i  = 1'b0;
        wb_we_i   = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    // Drives len cycles of an 8N1 frame; optionally issues one read of probe_addr
    // on the clock edge numbered probe_tick (1-based from the start-bit edge).
    task automatic drive_frame(input logic [7:0] d, input logic stop, input int len,
                               input int probe_tick, input logic [1:0] probe_addr,
                               output logic [7:0] probe_data);
        logic [9:0] bits;
        bits       = {stop, d, 1'b0};
        probe_data = 8'h00;
        for (int i = 0; i < len; i++) begin
            uart_rx = bits[i / CLK_DIV];
            if (i + 1 == probe_tick) begin
                wb_cyc_i  = 1'b1;
                wb_we_i   = 1'b0;
                wb_addr_i = probe_addr;
            end
            tick();
            if (i + 1 == probe_tick) begin
                wb_cyc_i   = 1'b0;
                probe_data = wb_datr_o;
            end
        end
        if (len >= FRAME_LEN) uart_rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        logic [7:0] dummy;
        drive_frame(d, stop, FRAME_LEN, -1, 2'd0, dummy);
        repeat (4) tick();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_status;
        logic [7:0] exp_count;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] probe;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h55, 1'b1, 8'h01, 8'h01, 8'h55};
        vecs[1] = '{8'hA3, 1'b0, 8'h08, 8'h00, 8'h00};
        vecs[2] = '{8'h00, 1'b1, 8'h01, 8'h01, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 8'h01, 8'h01, 8'hFF};
        vecs[4] = '{8'hA3, 1'b1, 8'h01, 8'h01, 8'hA3};
        vecs[5] = '{8'h3C, 1'b0, 8'h08, 8'h00, 8'h00};

        repeat (3) tick();
        check("reset datr", wb_datr_o, 8'h00);
        check("reset int", {7'b0, wb_int_o}, 8'h00);
        rst_i = 1'b1;
        repeat (4) tick();
        for (int a = 0; a < 4; a++) begin
            read_check($sformatf("reset reg%0d", a), 2'(a), 8'h00);
        end

        // Stop-bit sample lands on edge 79: status read there is still empty.
        drive_frame(8'h55, 1'b1, FRAME_LEN, 79, 2'd1, probe);
        check("latency status@stop", probe, 8'h00);
        read_check("latency status after", 2'd1, 8'h01);
        read_check("latency data", 2'd0, 8'h55);
        read_check("latency status drained", 2'd1, 8'h00);
        read_check("empty read", 2'd0, 8'h00);

        for (int v = 0; v < 6; v++) begin
            send(vecs[v].data, vecs[v].stop);
            read_check($sformatf("vec%0d status", v), 2'd1, vecs[v].exp_status);
            read_check($sformatf("vec%0d count", v), 2'd3, vecs[v].exp_count);
            read_check($sformatf("vec%0d data", v), 2'd0, vecs[v].exp_data);
            bus_write(2'd1, 8'h0C);
            read_check($sformatf("vec%0d status clr", v), 2'd1, 8'h00);
        end

        // Short low glitch must be rejected at the mid-start sample.
        uart_rx = 1'b0;
        repeat (3) tick();
        uart_rx = 1'b1;
        repeat (12) tick();
        read_check("glitch status", 2'd1, 8'h00);
        read_check("glitch count", 2'd3, 8'h00);
        send(8'h69, 1'b1);
        read_check("post glitch data", 2'd0, 8'h69);

        for (int k = 1; k <= 9; k++) send(8'(k), 1'b1);
        read_check("ovr count", 2'd3, 8'h08);
        read_check("ovr status", 2'd1, 8'h07);
        for (int k = 1; k <= 8; k++) begin
            read_check($sformatf("ovr drain%0d", k), 2'd0, 8'(k));
        end
        read_check("ovr status drained", 2'd1, 8'h04);
        bus_write(2'd3, 8'hFF);
        read_check("count write ignored", 2'd3, 8'h00);
        bus_write(2'd1, 8'h04);
        read_check("ovr cleared", 2'd1, 8'h00);

        // Full FIFO: a pop on the same edge as the stop-bit push avoids overrun.
        for (int k = 1; k <= 8; k++) send(8'(k), 1'b1);
        read_check("full status", 2'd1, 8'h03);
        drive_frame(8'h42, 1'b1, FRAME_LEN, 79, 2'd0, probe);
        check("collide pop data", probe, 8'h01);
        repeat (4) tick();
        read_check("collide status", 2'd1, 8'h03);
        read_check("collide count", 2'd3, 8'h08);
        for (int k = 2; k <= 8; k++) begin
            read_check($sformatf("collide drain%0d", k), 2'd0, 8'(k));
        end
        read_check("collide last", 2'd0, 8'h42);
        read_check("collide status end", 2'd1, 8'h00);

        bus_write(2'd2, 8'hFF);
        read_check("ctrl ie", 2'd2, 8'h01);
        check("int idle", {7'b0, wb_int_o}, 8'h00);
        send(8'h5A, 1'b1);
        check("int raised", {7'b0, wb_int_o}, 8'h01);
        read_check("int data", 2'd0, 8'h5A);
        repeat (2) tick();
        check("int cleared", {7'b0, wb_int_o}, 8'h00);

        send(8'h11, 1'b1);
        check("int before reset", {7'b0, wb_int_o}, 8'h01);
        drive_frame(8'h96, 1'b1, 30, -1, 2'd0, probe);
        rst_i = 1'b0;
        #1;
        check("midreset datr", wb_datr_o, 8'h00);
        check("midreset int", {7'b0, wb_int_o}, 8'h00);
        repeat (2) tick();
        uart_rx = 1'b1;
        rst_i   = 1'b1;
        repeat (4) tick();
        read_check("midreset ctrl", 2'd2, 8'h00);
        read_check("midreset count", 2'd3, 8'h00);
        read_check("midreset status", 2'd1, 8'h00);
        send(8'h3C, 1'b1);
        read_check("post reset count", 2'd3, 8'h01);
        read_check("post reset data", 2'd0, 8'h3C);
        check("post reset int", {7'b0, wb_int_o}, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
